// File: rtl/neuron_grid_pkg.sv
// rtl/neuron_grid_pkg.sv - shared types and default widths for neuron grid routing blocks
package neuron_grid_pkg;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_NEURON_W  = 8;
   localparam int DEF_CNT_W     = 16;
   localparam int DEF_CORE_W    = $clog2(DEF_NUM_CORES);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [DEF_CORE_W-1:0]   core_id;
      logic [DEF_NEURON_W-1:0] neuron;
   } spike_pkt_t;

endpackage

// File: rtl/spike_router_arbiter_if.sv
// rtl/spike_router_arbiter_if.sv - request, output and control bundle of the spike router arbiter
interface spike_router_arbiter_if
   import neuron_grid_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int NEURON_W  = DEF_NEURON_W,
   parameter int CNT_W     = DEF_CNT_W
);
   localparam int CORE_W = $clog2(NUM_CORES);

   logic                          tick;
   logic [NUM_CORES-1:0]          req;
   logic [NUM_CORES*NEURON_W-1:0] req_neuron;
   logic [NUM_CORES-1:0]          gnt;
   logic                          out_valid;
   logic                          out_ready;
   logic [CORE_W-1:0]             out_core;
   logic [NEURON_W-1:0]           out_neuron;
   logic                          flush_req;
   logic                          flush_done;
   logic                          tick_err;
   logic [CNT_W-1:0]              last_tick_count;

   modport master (
      output tick, req, req_neuron, out_ready, flush_req,
      input  gnt, out_valid, out_core, out_neuron, flush_done, tick_err, last_tick_count
   );

   modport slave (
      input  tick, req, req_neuron, out_ready, flush_req,
      output gnt, out_valid, out_core, out_neuron, flush_done, tick_err, last_tick_count
   );

endinterface

// File: rtl/spike_router_arbiter_rr_pick.sv
// rtl/spike_router_arbiter_rr_pick.sv - rotating priority encoder, first request at or after ptr
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);

   logic found;
   int   j;

   // scan ptr, ptr+1, ... modulo N and keep the first asserted request
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = W'(j);
         end
      end
   end

endmodule

// File: rtl/spike_router_arbiter.sv
// rtl/spike_router_arbiter.sv - round-robin spike arbiter with output register, drain and tick statistics
module spike_router_arbiter
   import neuron_grid_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int NEURON_W  = DEF_NEURON_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   spike_router_arbiter_if.slave  bus
);

   localparam int                CORE_W    = $clog2(NUM_CORES);
   localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

   arb_state_t           state, state_nxt;
   logic [CORE_W-1:0]    rr_ptr, pick_idx, out_core_q;
   logic [NUM_CORES-1:0] pick_gnt, gnt_c;
   logic [NEURON_W-1:0]  pick_neuron, out_neuron_q;
   logic                 out_valid_q, slot_free, accept, tick_err_q;
   logic [CNT_W-1:0]     spike_cnt, cnt_next, last_cnt_q;

   rr_pick #(.N(NUM_CORES)) u_pick (
      .req (bus.req),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   assign slot_free = ~out_valid_q | bus.out_ready;
   assign accept    = out_valid_q & bus.out_ready;
   // grants only while running with room in the output stage; forced low while reset is held
   assign gnt_c     = (reset_n && state == ST_RUN && slot_free) ? pick_gnt : '0;

   // one-hot select of the granted core's neuron index
   always_comb begin
      pick_neuron = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (pick_gnt[k]) pick_neuron = bus.req_neuron[k*NEURON_W +: NEURON_W];
      end
   end

   // saturating increment of the per-tick delivered spike count
   always_comb begin
      cnt_next = spike_cnt;
      if (accept && spike_cnt != '1) cnt_next = spike_cnt + 1'b1;
   end

   // drain sequencing: stop granting, wait for the output stage to empty, pulse done
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (bus.flush_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!out_valid_q || bus.out_ready) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_RUN;
      else          state <= state_nxt;
   end

   // output register: load on grant, otherwise empty once accepted; pointer moves past the winner
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q  <= 1'b0;
         out_core_q   <= '0;
         out_neuron_q <= '0;
         rr_ptr       <= '0;
      end else if (|gnt_c) begin
         out_valid_q  <= 1'b1;
         out_core_q   <= pick_idx;
         out_neuron_q <= pick_neuron;
         rr_ptr       <= (pick_idx == LAST_CORE) ? '0 : pick_idx + 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end

   // tick snapshots the count including a same-cycle acceptance, then restarts it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spike_cnt  <= '0;
         last_cnt_q <= '0;
      end else if (bus.tick) begin
         last_cnt_q <= cnt_next;
         spike_cnt  <= '0;
      end else begin
         spike_cnt  <= cnt_next;
      end
   end

   // sticky flag for a tick that arrives while traffic or a drain is still in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick_err_q <= 1'b0;
      else if (bus.tick && (|bus.req || out_valid_q || state != ST_RUN)) tick_err_q <= 1'b1;
   end

   assign bus.gnt             = gnt_c;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_core        = out_core_q;
   assign bus.out_neuron      = out_neuron_q;
   assign bus.flush_done      = (state == ST_DONE);
   assign bus.tick_err        = tick_err_q;
   assign bus.last_tick_count = last_cnt_q;

endmodule

// File: doc/spike_router_arbiter.md
Name: spike_router_arbiter

Overview:
Round-robin arbiter that shares one outbound spike-router port among NUM_CORES neuron grid cores. Each core presents a fired-neuron index with a request. The arbiter grants one core per cycle and captures {core_id, neuron} into a single-stage output register with a valid/ready handshake. It provides an end-of-timestep drain (flush) handshake, per-tick spike statistics, and a sticky error for late ticks.

Parameters:
NUM_CORES, 4, number of requesting cores (≥2)
NEURON_W, 8, neuron index width
CORE_W, $clog2(NUM_CORES), core id width (derived, localparam)
CNT_W, 16, spike counter width

Ports:
clk  in  1  clock
reset_n  in  1  reset
tick  in  1  timestep boundary pulse, 1 cycle
req  in  NUM_CORES  per-core spike request, held until granted
req_neuron  in  NUM_CORES*NEURON_W  packed neuron index, core k at [k*NEURON_W +: NEURON_W], stable while req[k]
gnt  out  NUM_CORES  one-hot grant pulse
out_valid  out  1  output packet valid
out_ready  in  1  downstream accept
out_core  out  CORE_W  granted core id
out_neuron  out  NEURON_W  granted neuron index
flush_req  in  1  request drain before tick
flush_done  out  1  1-cycle pulse, drain complete
tick_err  out  1  sticky late-tick error
last_tick_count  out  CNT_W  spikes delivered during previous timestep

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk. In reset: state=RUN, rr_ptr=0, out_valid=0, out_core=0, out_neuron=0, gnt=0, flush_done=0, tick_err=0, spike_cnt=0, last_tick_count=0.
- slot_free = ~out_valid | out_ready.
- Grant (combinational from registered state):
  - When state==RUN, slot_free, and |req: gnt = first set bit of req scanning rr_ptr, rr_ptr+1, … modulo NUM_CORES. Otherwise gnt=0.
  - gnt is never asserted in DRAIN/DONE.
- Capture: on a cycle with |gnt, the next edge loads out_core=k and out_neuron=req_neuron[k], sets out_valid=1, and sets rr_ptr=(k+1) mod NUM_CORES (wraps N-1→0).
- Requester handshake: a core sees gnt[k] high in the cycle its request is consumed. It drops req or presents a new neuron on the following cycle.
- Output register:
  - out_valid=1 with out_ready=0 holds data stable.
  - out_valid=1 with out_ready=1 and no gnt clears out_valid.
  - out_valid=1 with out_ready=1 and a gnt replaces the data; out_valid stays 1. This gives 1 packet/cycle sustained.
  - Latency from req to out_valid is 1 cycle.
- spike_cnt increments on each out_valid&out_ready and saturates at 2^CNT_W-1.
- FSM:
  - RUN: flush_req → DRAIN. Any grant in that same cycle still completes.
  - DRAIN: no grants. When out_valid==0, or out_valid&out_ready, → DONE.
  - DONE: flush_done=1 for exactly one cycle, then → RUN.
- Tick:
  - On tick, last_tick_count ← spike_cnt, including a same-cycle acceptance (+1, saturating). spike_cnt ← 0.
  - tick_err sets if tick arrives while (|req | out_valid) or state!=RUN. It clears only on reset.
  - A tick during DRAIN does not abort the drain.
- Simultaneous tick and flush_req: both take effect.
- Reset mid-packet drops the packet, with no flush_done.

Decomposition:
- Shared package neuron_grid_pkg: arbiter state encoding (RUN=0, DRAIN=1, DONE=2), a spike packet struct {core_id, neuron}, and the default widths.
- Sub-module rr_pick: a combinational rotating priority encoder with inputs req and ptr, outputs one-hot gnt and binary idx. It is reusable by future router arbiters.

Test Plan:
- Setup for all scenarios: NUM_CORES=4.
- Reset then idle → all outputs 0, including last_tick_count=0 and tick_err=0.
- req=4'b1111 held, out_ready=1 → grant order 0,1,2,3,0,… with one gnt per cycle. out_core follows 1 cycle later, and out_neuron=req_neuron of the granted core.
- Single packet core2 neuron 0x5A with out_ready=0 for 3 cycles → out_valid held, data stable, gnt=0 on the other requests. When ready rises, the packet is accepted and the next grant goes to core3, rr_ptr wrapping to 0 after it.
- flush_req with out_valid=1 and out_ready low 2 cycles → no grants. flush_done pulses exactly 1 cycle after acceptance, then RUN resumes.
- Deliver 7 packets, then tick with req=0 and out_valid=0 → last_tick_count=7, tick_err=0. Then tick with req[1]=1 → tick_err=1, which stays set until reset.
- Saturation with CNT_W=4: 20 packets then tick → last_tick_count=15.
